// File: rtl/alu_execute_unit.sv
// rtl/alu_execute_unit.sv - execute-stage ALU with serial SLL/SRL and valid/ready result handshake
module alu_execute_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [3:0]         ALU_Control,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [WIDTH-1:0]   Result,
    output logic               Zero,
    output logic               Busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [WIDTH-1:0]   r_shreg;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_shift_left;

    logic               w_accept;
    logic               w_is_shift;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_shift_next;

    assign In_Ready  = (r_state == ST_IDLE);
    assign Out_Valid = (r_state == ST_DONE);
    assign Busy      = (r_state == ST_SHIFT);
    assign Result    = r_result;
    assign Zero      = r_zero;

    assign w_accept     = In_Valid && In_Ready;
    assign w_is_shift   = (ALU_Control == OP_SLL) || (ALU_Control == OP_SRL);
    assign w_shift_next = r_shift_left ? (r_shreg << 1) : (r_shreg >> 1);

    // Shift codes map to B so a zero shift amount completes in a single cycle;
    // unknown codes fall through to 0, which also yields Zero=1.
    always_comb begin
        w_alu = '0;
        case (ALU_Control)
            OP_ADD:  w_alu = A + B;
            OP_SUB:  w_alu = A - B;
            OP_SLL:  w_alu = B;
            OP_SRL:  w_alu = B;
            OP_AND:  w_alu = A & B;
            OP_OR:   w_alu = A | B;
            OP_NOR:  w_alu = ~(A | B);
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_shift_left <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift && (Shamt != '0)) begin
                            r_shreg      <= B;
                            r_cnt        <= Shamt;
                            r_shift_left <= (ALU_Control == OP_SLL);
                            r_state      <= ST_SHIFT;
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= w_shift_next;
                    r_cnt   <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_result <= w_shift_next;
                        r_zero   <= (w_shift_next == '0);
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (Out_Ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_execute_unit.sv
// tb/tb_alu_execute_unit.sv - randomized and directed self-checking bench for alu_execute_unit
module tb_alu_execute_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        In_Valid;
    logic        In_Ready;
    logic [3:0]  ALU_Control;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Result;
    logic        Zero;
    logic        Busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_execute_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .ALU_Control(ALU_Control), .A(A), .B(B), .Shamt(Shamt),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Result(Result), .Zero(Zero), .Busy(Busy)
    );

    function automatic logic [31:0] model_f(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] s);
        case (c)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return b << s;
            4'd4:    return b >> s;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return ~(a | b);
            4'd8:    return (a < b) ? 32'd1 : 32'd0;
            4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Transaction-level model: one op outstanding, m_wait shift cycles before its result shows.
    logic        m_have;
    logic [4:0]  m_wait;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have <= 1'b0;
            m_wait <= 5'd0;
            m_res  <= 32'd0;
        end else if (!m_have) begin
            if (In_Valid) begin
                m_have <= 1'b1;
                m_wait <= ((ALU_Control == 4'd3 || ALU_Control == 4'd4) && Shamt != 5'd0) ? Shamt : 5'd0;
                m_res  <= model_f(ALU_Control, A, B, Shamt);
            end
        end else if (m_wait != 5'd0) begin
            m_wait <= m_wait - 5'd1;
        end else if (Out_Ready) begin
            m_have <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        if (rst_n) begin
            chk("in_ready", {31'd0, In_Ready}, {31'd0, !m_have});
            chk("busy", {31'd0, Busy}, {31'd0, m_have && (m_wait != 5'd0)});
            chk("out_valid", {31'd0, Out_Valid}, {31'd0, m_have && (m_wait == 5'd0)});
            if (m_have && m_wait == 5'd0) begin
                chk("result", Result, m_res);
                chk("zero", {31'd0, Zero}, {31'd0, m_res == 32'd0});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] s, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_busy, input bit hold);
        int k;
        int n;
        int nb;
        chk({name, "_model"}, model_f(c, a, b, s), exp_res);
        k = 0;
        while (!In_Ready && k < 200) begin
            tick();
            k++;
        end
        chk({name, "_idle"}, {31'd0, In_Ready}, 32'd1);
        ALU_Control = c; A = a; B = b; Shamt = s;
        In_Valid = 1'b1;
        Out_Ready = !hold;
        tick();
        // Scramble inputs after accept; the op in flight must not see them.
        In_Valid = 1'b0;
        A = $urandom; B = $urandom; ALU_Control = 4'($urandom); Shamt = 5'($urandom);
        n = 1;
        nb = 0;
        while (!Out_Valid && n < 100) begin
            if (Busy) nb++;
            tick();
            n++;
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_busy_cycles"}, nb, exp_busy);
        chk({name, "_result"}, Result, exp_res);
        chk({name, "_zero"}, {31'd0, Zero}, {31'd0, exp_res == 32'd0});
        if (hold) begin
            for (int i = 0; i < 2; i++) begin
                tick();
                chk({name, "_hold_result"}, Result, exp_res);
                chk({name, "_hold_in_ready"}, {31'd0, In_Ready}, 32'd0);
                chk({name, "_hold_valid"}, {31'd0, Out_Valid}, 32'd1);
            end
            Out_Ready = 1'b1;
        end
        tick();
        chk({name, "_released"}, {31'd0, In_Ready}, 32'd1);
    endtask

    initial begin
        In_Valid = 1'b0; Out_Ready = 1'b0; ALU_Control = 4'd0;
        A = 32'd0; B = 32'd0; Shamt = 5'd0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_result", Result, 32'd0);
        chk("reset_zero", {31'd0, Zero}, 32'd0);
        chk("reset_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        #9 rst_n = 1'b1;
        tick();
        chk("post_reset_in_ready", {31'd0, In_Ready}, 32'd1);

        run_op("add",      4'd1, 32'd5,        32'd7,        5'd0,  32'd12,       1,  0,  1'b0);
        run_op("add_wrap", 4'd1, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        1,  0,  1'b0);
        run_op("sub_eq",   4'd2, 32'h1234,     32'h1234,     5'd0,  32'd0,        1,  0,  1'b0);
        run_op("slt",      4'd9, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1,  0,  1'b0);
        run_op("sltu",     4'd8, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        1,  0,  1'b0);
        run_op("sll31",    4'd3, 32'd0,        32'd1,        5'd31, 32'h80000000, 32, 31, 1'b0);
        run_op("srl4",     4'd4, 32'd0,        32'h80000000, 5'd4,  32'h08000000, 5,  4,  1'b0);
        run_op("sll0",     4'd3, 32'd0,        32'hABCD,     5'd0,  32'hABCD,     1,  0,  1'b0);
        run_op("and",      4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1,  0,  1'b0);
        run_op("or",       4'd6, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1,  0,  1'b0);
        run_op("nor",      4'd7, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1,  0,  1'b0);
        run_op("bad_op0",  4'd0, 32'h55,       32'h66,       5'd3,  32'd0,        1,  0,  1'b0);
        run_op("bad_op12", 4'd12, 32'h55,      32'h66,       5'd3,  32'd0,        1,  0,  1'b0);
        run_op("hold",     4'd1, 32'd5,        32'd7,        5'd0,  32'd12,       1,  0,  1'b1);

        // Reset in the fifth shift cycle aborts the op with no result.
        ALU_Control = 4'd3; A = 32'd0; B = 32'd1; Shamt = 5'd20;
        In_Valid = 1'b1; Out_Ready = 1'b1;
        tick();
        In_Valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_shift_busy", {31'd0, Busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_result", Result, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        chk("abort_idle", {31'd0, In_Ready}, 32'd1);

        for (int i = 0; i < 4000; i++) begin
            In_Valid    = ($urandom % 4) != 0;
            ALU_Control = ($urandom % 8 == 0) ? 4'($urandom) : 4'($urandom_range(1, 9));
            A           = ($urandom % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            B           = ($urandom % 4 == 0) ? A : $urandom;
            Shamt       = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
            Out_Ready   = ($urandom % 4) != 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
